cpu_lsu: RTL and testbench
==========================

Name: cpu_lsu

Overview:
- Load/store unit between the CPU datapath and the Avalon-style data memory bus.
- Takes the effective address and the rt store value from the datapath. Runs one bus read or write per request.
- Performs big-endian byte-lane placement for SB/SH and lane extraction with sign/zero extension for LB/LBU/LH/LHU.
- Returns a 32-bit load result to the register write-back path with a done pulse.

Parameters:
- MAX_WAIT_CYCLES, 0: waitrequest timeout in cycles. 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start_i  in  1  request strobe, sampled only in IDLE.
- opcode_i  in  6  MIPS primary opcode of the request.
- effective_address_i  in  32  byte address (rs + sext(imm)).
- store_data_i  in  32  rt value, right-justified.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  valid with done_o: misaligned, unsupported opcode, or timeout.
- load_data_o  out  32  extended load result. Held until the next load completes.
- address_o  out  32  word-aligned bus address, {ea[31:2],2'b00}.
- read_o  out  1  bus read request.
- write_o  out  1  bus write request.
- byteenable_o  out  4  byte lanes. Bit 3 = bits 31:24.
- writedata_o  out  32  lane-placed store data.
- readdata_i  in  32  bus read data.
- waitrequest_i  in  1  bus stall.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; busy_o, done_o, error_o, read_o, write_o = 0; address_o, byteenable_o, writedata_o, load_data_o = 0; wait counter = 0. Reset during ISSUE drops read_o/write_o immediately and abandons the transfer.
- Supported opcodes: LB 0x20, LH 0x21, LW 0x23, LBU 0x24, LHU 0x25, SB 0x28, SH 0x29, SW 0x2B.
- Byte order is big-endian. Offset ea[1:0]=0 maps to bits 31:24.
  - Byte byteenable: 1000, 0100, 0010, 0001 for offsets 0..3.
  - Halfword byteenable: 1100 for offset 0, 0011 for offset 2.
  - Word byteenable: 1111.
- Store placement: SB replicates store_data_i[7:0] into all four lanes. SH replicates [15:0] into both halves. SW passes through.
- Load extraction: take the selected lane(s) from readdata_i and right-justify. LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Alignment rules: halfword requires ea[0]=0; word requires ea[1:0]=0.
- FSM states: IDLE, ISSUE, DONE.
  - IDLE, start_i=1, opcode supported and aligned: register address_o, byteenable_o, writedata_o, and the opcode. Assert read_o or write_o. Go to ISSUE.
  - IDLE, start_i=1, unsupported or misaligned: go to DONE with error flag set. No bus access occurs.
  - IDLE, start_i=0: stay.
  - ISSUE: hold all bus outputs stable while waitrequest_i=1, incrementing the wait counter.
    - On an edge with waitrequest_i=0: deassert read_o/write_o. For loads, capture the extended readdata_i into load_data_o. Go to DONE.
    - Timeout: if MAX_WAIT_CYCLES>0 and the counter reaches MAX_WAIT_CYCLES with waitrequest_i still 1, deassert the request, set the error flag, go to DONE. load_data_o is unchanged.
  - DONE: done_o=1 and error_o=flag for exactly one cycle. Clear the counter. Go to IDLE.
- Latency: start-to-done is 2 cycles with zero wait states (done_o high in the second cycle after the start edge). Add 1 cycle per waitrequest cycle. Error without bus access: done_o in the cycle after the start edge.
- start_i is ignored whenever busy_o=1; no queueing. start_i in the DONE cycle is also ignored. The next request is accepted in IDLE.
- read_o and write_o are never both 1. Both are 0 outside ISSUE.
- A store never modifies load_data_o. A failed load never modifies load_data_o.

Test Plan:
- LW, ea=0x1000, readdata=0xDEADBEEF, waitrequest=0 -> address_o=0x1000, byteenable_o=1111, read_o high 1 cycle; done_o 2 cycles after start; load_data_o=0xDEADBEEF, error_o=0.
- LB/LBU, ea=0x1003, readdata=0x11223380 -> byteenable_o=0001; LB gives 0xFFFFFF80, LBU gives 0x00000080. LH at ea=0x1002 with readdata 0x0000F00D -> 0xFFFFF00D.
- SB, ea=0x2001, store_data=0x123456AB -> write_o=1, address_o=0x2000, byteenable_o=0100, writedata_o=0xABABABAB. SH, ea=0x2002, store_data=0xCAFE -> byteenable_o=0011, writedata_o=0xCAFECAFE.
- waitrequest high 3 cycles on SW ea=0x3000, data=0x55AA55AA -> outputs stable all 3 cycles; done_o at start+5; start_i pulsed mid-transfer ignored.
- LW ea=0x1002 or opcode 0x22 -> no read_o/write_o; done_o=1 with error_o=1 one cycle after start; load_data_o unchanged. MAX_WAIT_CYCLES=4 with waitrequest stuck high -> read_o drops after 4 wait cycles; done_o with error_o=1.
- rst_n low during ISSUE -> read_o=0 immediately, busy_o=0. After release, a new LW completes normally.

Source files
------------

// File: rtl/cpu_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_lsu : big-endian load/store unit, one Avalon-style transfer per request |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module cpu_lsu #(
  parameter int unsigned MAX_WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [5:0]  opcode_i,
  input  logic [31:0] effective_address_i,
  input  logic [31:0] store_data_i,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] load_data_o,
  output logic [31:0] address_o,
  output logic        read_o,
  output logic        write_o,
  output logic [3:0]  byteenable_o,
  output logic [31:0] writedata_o,
  input  logic [31:0] readdata_i,
  input  logic        waitrequest_i
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] address_q, address_d;
  logic [3:0]  byteenable_q, byteenable_d;
  logic [31:0] writedata_q, writedata_d;
  logic [5:0]  opcode_q, opcode_d;
  logic [1:0]  offset_q, offset_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic [31:0] load_data_q, load_data_d;
  logic        error_q, error_d;
  logic [31:0] wait_cnt_q, wait_cnt_d;

  // Request decode: lane mask, replicated store data, legality
  logic        req_ok;
  logic        req_load;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic [1:0]  ea_off;

  assign ea_off = effective_address_i[1:0];

  always_comb begin
    req_ok    = 1'b0;
    req_load  = 1'b0;
    req_be    = 4'b0000;
    req_wdata = 32'h0;
    unique case (opcode_i)
      OP_LB, OP_LBU, OP_SB: begin
        req_ok    = 1'b1;
        req_load  = (opcode_i != OP_SB);
        req_be    = 4'b1000 >> ea_off;
        req_wdata = {4{store_data_i[7:0]}};
      end
      OP_LH, OP_LHU, OP_SH: begin
        req_ok    = ~ea_off[0];
        req_load  = (opcode_i != OP_SH);
        req_be    = ea_off[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{store_data_i[15:0]}};
      end
      OP_LW, OP_SW: begin
        req_ok    = (ea_off == 2'b00);
        req_load  = (opcode_i == OP_LW);
        req_be    = 4'b1111;
        req_wdata = store_data_i;
      end
      default: begin
        req_ok = 1'b0;
      end
    endcase
  end

  // Lane extraction from the returned word, offset 0 being the MSB lane
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] rd_ext;

  always_comb begin
    unique case (offset_q)
      2'd0:    rd_byte = readdata_i[31:24];
      2'd1:    rd_byte = readdata_i[23:16];
      2'd2:    rd_byte = readdata_i[15:8];
      default: rd_byte = readdata_i[7:0];
    endcase
    rd_half = offset_q[1] ? readdata_i[15:0] : readdata_i[31:16];
    unique case (opcode_q)
      OP_LB:   rd_ext = {{24{rd_byte[7]}}, rd_byte};
      OP_LBU:  rd_ext = {24'h0, rd_byte};
      OP_LH:   rd_ext = {{16{rd_half[15]}}, rd_half};
      OP_LHU:  rd_ext = {16'h0, rd_half};
      default: rd_ext = readdata_i;
    endcase
  end

  logic wait_expired;
  assign wait_expired = (MAX_WAIT_CYCLES != 0) &&
                        ((wait_cnt_q + 32'd1) >= MAX_WAIT_CYCLES);

  always_comb begin
    state_d      = state_q;
    address_d    = address_q;
    byteenable_d = byteenable_q;
    writedata_d  = writedata_q;
    opcode_d     = opcode_q;
    offset_d     = offset_q;
    read_d       = read_q;
    write_d      = write_q;
    load_data_d  = load_data_q;
    error_d      = error_q;
    wait_cnt_d   = wait_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          if (req_ok) begin
            address_d    = {effective_address_i[31:2], 2'b00};
            byteenable_d = req_be;
            writedata_d  = req_wdata;
            opcode_d     = opcode_i;
            offset_d     = ea_off;
            read_d       = req_load;
            write_d      = ~req_load;
            error_d      = 1'b0;
            wait_cnt_d   = 32'h0;
            state_d      = ISSUE;
          end else begin
            error_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (!waitrequest_i) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          error_d = 1'b0;
          if (read_q) begin
            load_data_d = rd_ext;
          end
          state_d = DONE;
        end else if (wait_expired) begin
          read_d  = 1'b0;
          write_d = 1'b0;
          error_d = 1'b1;
          state_d = DONE;
        end else begin
          wait_cnt_d = wait_cnt_q + 32'd1;
        end
      end
      DONE: begin
        wait_cnt_d = 32'h0;
        state_d    = IDLE;
      end
      default: begin
        read_d  = 1'b0;
        write_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      address_q    <= 32'h0;
      byteenable_q <= 4'h0;
      writedata_q  <= 32'h0;
      opcode_q     <= 6'h0;
      offset_q     <= 2'd0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      load_data_q  <= 32'h0;
      error_q      <= 1'b0;
      wait_cnt_q   <= 32'h0;
    end else begin
      state_q      <= state_d;
      address_q    <= address_d;
      byteenable_q <= byteenable_d;
      writedata_q  <= writedata_d;
      opcode_q     <= opcode_d;
      offset_q     <= offset_d;
      read_q       <= read_d;
      write_q      <= write_d;
      load_data_q  <= load_data_d;
      error_q      <= error_d;
      wait_cnt_q   <= wait_cnt_d;
    end
  end

  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == DONE);
  assign error_o      = (state_q == DONE) && error_q;
  assign load_data_o  = load_data_q;
  assign address_o    = address_q;
  assign read_o       = read_q;
  assign write_o      = write_q;
  assign byteenable_o = byteenable_q;
  assign writedata_o  = writedata_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_lsu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_cpu_lsu : directed self-checking bench for cpu_lsu (MAX_WAIT_CYCLES=4)  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_cpu_lsu;

  logic        clk;
  logic        rst_n;
  logic        start_i;
  logic [5:0]  opcode_i;
  logic [31:0] effective_address_i;
  logic [31:0] store_data_i;
  logic        busy_o;
  logic        done_o;
  logic        error_o;
  logic [31:0] load_data_o;
  logic [31:0] address_o;
  logic        read_o;
  logic        write_o;
  logic [3:0]  byteenable_o;
  logic [31:0] writedata_o;
  logic [31:0] readdata_i;
  logic        waitrequest_i;

  int total;
  int bad;

  cpu_lsu #(.MAX_WAIT_CYCLES(4)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start_i             (start_i),
    .opcode_i            (opcode_i),
    .effective_address_i (effective_address_i),
    .store_data_i        (store_data_i),
    .busy_o              (busy_o),
    .done_o              (done_o),
    .error_o             (error_o),
    .load_data_o         (load_data_o),
    .address_o           (address_o),
    .read_o              (read_o),
    .write_o             (write_o),
    .byteenable_o        (byteenable_o),
    .writedata_o         (writedata_o),
    .readdata_i          (readdata_i),
    .waitrequest_i       (waitrequest_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [5:0] op, input logic [31:0] ea, input logic [31:0] sd);
    opcode_i            = op;
    effective_address_i = ea;
    store_data_i        = sd;
    start_i             = 1'b1;
    tick();
    start_i = 1'b0;
  endtask

  // Zero-wait load: checks the ISSUE cycle then the DONE cycle
  task automatic load_case(input string tag, input logic [5:0] op, input logic [31:0] ea,
                           input logic [31:0] rd, input logic [3:0] be, input logic [31:0] exp);
    readdata_i    = rd;
    waitrequest_i = 1'b0;
    issue(op, ea, 32'h0);
    chk({tag, ".read"}, {31'h0, read_o}, 32'h1);
    chk({tag, ".write"}, {31'h0, write_o}, 32'h0);
    chk({tag, ".addr"}, address_o, {ea[31:2], 2'b00});
    chk({tag, ".be"}, {28'h0, byteenable_o}, {28'h0, be});
    chk({tag, ".done_early"}, {31'h0, done_o}, 32'h0);
    tick();
    chk({tag, ".done"}, {31'h0, done_o}, 32'h1);
    chk({tag, ".err"}, {31'h0, error_o}, 32'h0);
    chk({tag, ".read_drop"}, {31'h0, read_o}, 32'h0);
    chk({tag, ".data"}, load_data_o, exp);
    tick();
    chk({tag, ".idle"}, {31'h0, busy_o}, 32'h0);
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst_n = 1'b0;
    start_i = 1'b0;
    opcode_i = 6'h0;
    effective_address_i = 32'h0;
    store_data_i = 32'h0;
    readdata_i = 32'h0;
    waitrequest_i = 1'b0;
    tick();
    tick();
    chk("rst.busy", {31'h0, busy_o}, 32'h0);
    chk("rst.done", {31'h0, done_o}, 32'h0);
    chk("rst.err", {31'h0, error_o}, 32'h0);
    chk("rst.rw", {30'h0, read_o, write_o}, 32'h0);
    chk("rst.addr", address_o, 32'h0);
    chk("rst.be", {28'h0, byteenable_o}, 32'h0);
    chk("rst.wdata", writedata_o, 32'h0);
    chk("rst.ldata", load_data_o, 32'h0);
    rst_n = 1'b1;
    tick();

    load_case("lw", 6'h23, 32'h0000_1000, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF);
    load_case("lb", 6'h20, 32'h0000_1003, 32'h11223380, 4'b0001, 32'hFFFFFF80);
    load_case("lbu", 6'h24, 32'h0000_1003, 32'h11223380, 4'b0001, 32'h00000080);
    load_case("lb0", 6'h20, 32'h0000_1000, 32'h7F223380, 4'b1000, 32'h0000007F);
    load_case("lbu1", 6'h24, 32'h0000_1001, 32'h11A23380, 4'b0100, 32'h000000A2);
    load_case("lh", 6'h21, 32'h0000_1002, 32'h0000F00D, 4'b0011, 32'hFFFFF00D);
    load_case("lhu", 6'h25, 32'h0000_1000, 32'h8001_1234, 4'b1100, 32'h00008001);
    load_case("lh0", 6'h21, 32'h0000_1000, 32'h8001_1234, 4'b1100, 32'hFFFF8001);
    load_case("lh2", 6'h21, 32'h0000_1002, 32'h0000F00D, 4'b0011, 32'hFFFFF00D);

    // SB at offset 1
    issue(6'h28, 32'h0000_2001, 32'h123456AB);
    chk("sb.write", {31'h0, write_o}, 32'h1);
    chk("sb.read", {31'h0, read_o}, 32'h0);
    chk("sb.addr", address_o, 32'h0000_2000);
    chk("sb.be", {28'h0, byteenable_o}, 32'h4);
    chk("sb.wdata", writedata_o, 32'hABABABAB);
    tick();
    chk("sb.done", {31'h0, done_o}, 32'h1);
    chk("sb.err", {31'h0, error_o}, 32'h0);
    chk("sb.ldata_kept", load_data_o, 32'hFFFFF00D);
    tick();

    issue(6'h29, 32'h0000_2002, 32'h0000CAFE);
    chk("sh.write", {31'h0, write_o}, 32'h1);
    chk("sh.be", {28'h0, byteenable_o}, 32'h3);
    chk("sh.wdata", writedata_o, 32'hCAFECAFE);
    tick();
    chk("sh.done", {31'h0, done_o}, 32'h1);
    tick();

    // SW with three wait states and an ignored mid-transfer start
    waitrequest_i = 1'b1;
    issue(6'h2B, 32'h0000_3000, 32'h55AA55AA);
    for (int i = 0; i < 3; i++) begin
      chk("sww.write", {31'h0, write_o}, 32'h1);
      chk("sww.addr", address_o, 32'h0000_3000);
      chk("sww.be", {28'h0, byteenable_o}, 32'hF);
      chk("sww.wdata", writedata_o, 32'h55AA55AA);
      chk("sww.done", {31'h0, done_o}, 32'h0);
      if (i == 1) begin
        issue(6'h23, 32'h0000_4000, 32'h0);
      end else begin
        tick();
      end
    end
    waitrequest_i = 1'b0;
    chk("sww.write4", {31'h0, write_o}, 32'h1);
    chk("sww.addr4", address_o, 32'h0000_3000);
    tick();
    chk("sww.done5", {31'h0, done_o}, 32'h1);
    chk("sww.err", {31'h0, error_o}, 32'h0);
    chk("sww.rw_off", {30'h0, read_o, write_o}, 32'h0);
    tick();
    chk("sww.idle", {31'h0, busy_o}, 32'h0);
    tick();
    chk("sww.no_queue", {30'h0, read_o, write_o}, 32'h0);

    // Misaligned word and unsupported opcode
    issue(6'h23, 32'h0000_1002, 32'h0);
    chk("mis.rw", {30'h0, read_o, write_o}, 32'h0);
    chk("mis.done", {31'h0, done_o}, 32'h1);
    chk("mis.err", {31'h0, error_o}, 32'h1);
    chk("mis.ldata", load_data_o, 32'hFFFFF00D);
    tick();
    issue(6'h22, 32'h0000_1000, 32'h0);
    chk("bad_op.rw", {30'h0, read_o, write_o}, 32'h0);
    chk("bad_op.done", {31'h0, done_o}, 32'h1);
    chk("bad_op.err", {31'h0, error_o}, 32'h1);
    tick();
    issue(6'h29, 32'h0000_2001, 32'h0);
    chk("mis_sh.err", {31'h0, error_o}, 32'h1);
    tick();

    // Timeout after four wait cycles
    waitrequest_i = 1'b1;
    readdata_i = 32'h99999999;
    issue(6'h23, 32'h0000_5000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk("to.read", {31'h0, read_o}, 32'h1);
      chk("to.done", {31'h0, done_o}, 32'h0);
      tick();
    end
    chk("to.read_drop", {31'h0, read_o}, 32'h0);
    chk("to.done5", {31'h0, done_o}, 32'h1);
    chk("to.err", {31'h0, error_o}, 32'h1);
    chk("to.ldata", load_data_o, 32'hFFFFF00D);
    tick();
    chk("to.idle", {31'h0, busy_o}, 32'h0);

    // Asynchronous reset in the middle of ISSUE
    issue(6'h23, 32'h0000_6000, 32'h0);
    chk("ar.read", {31'h0, read_o}, 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar.read_drop", {31'h0, read_o}, 32'h0);
    chk("ar.busy", {31'h0, busy_o}, 32'h0);
    chk("ar.ldata", load_data_o, 32'h0);
    tick();
    rst_n = 1'b1;
    waitrequest_i = 1'b0;
    tick();
    load_case("lw_after", 6'h23, 32'h0000_1000, 32'h0BADF00D, 4'b1111, 32'h0BADF00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
